// File: rtl/axi3_arb_pkg.sv
// Shared types for the two-master AXI3 write arbiter.
// Struct widths follow the default DATAWIDTH=32 / SIZE=3 build.
package axi3_arb_pkg;

    localparam int ARB_DW   = 32;
    localparam int ARB_SIZE = 3;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = ARB_DW / 8;
    localparam int ID_W     = ARB_DW / 8;
    localparam int STRB_W   = ARB_DW / 8;
    localparam int BURST_W  = ARB_SIZE - 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [ARB_SIZE-1:0] size;
        logic [BURST_W-1:0]  burst;
        logic [ID_W-1:0]     id;
    } aw_t;

    typedef struct packed {
        logic [ARB_DW-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// ptr names the requester that wins a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    // A lone requester wins outright; a tie goes to ptr.
    always_comb begin
        win = req;
        if (&req) begin
            win = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi3_write_arbiter.sv
// Two-master AXI3 write arbiter.
// One owner holds AW, all W beats and B end to end.
module axi3_write_arbiter
    import axi3_arb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SIZE      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] m_awvalid,
    output logic [1:0] m_awready,
    input  aw_t  [1:0] m_aw,
    input  logic [1:0] m_wvalid,
    output logic [1:0] m_wready,
    input  w_t   [1:0] m_w,
    output logic [1:0] m_bvalid,
    input  logic [1:0] m_bready,
    output logic [1:0] m_bresp,
    output logic       s_awvalid,
    input  logic       s_awready,
    output aw_t        s_aw,
    output logic       s_wvalid,
    input  logic       s_wready,
    output w_t         s_w,
    input  logic       s_bvalid,
    output logic       s_bready,
    input  logic [1:0] s_bresp,
    output logic [1:0] grant
);

    localparam int CNT_W = DATAWIDTH / 8;

    state_e           state_q;
    logic [1:0]       grant_q;
    logic             ptr_q;
    logic [CNT_W-1:0] beat_q;

    logic [1:0] win;
    logic       gidx;
    aw_t        aw_sel;

    assign grant  = grant_q;
    assign gidx   = grant_q[1];
    assign aw_sel = m_aw[gidx];

    rr_pick2 u_pick (
        .req (m_awvalid),
        .ptr (ptr_q),
        .win (win)
    );

    // Route the owner's channels to the slave for the current phase only.
    always_comb begin
        m_awready    = '0;
        m_wready     = '0;
        m_bvalid     = '0;
        m_bresp      = OKAY;
        s_awvalid    = 1'b0;
        s_wvalid     = 1'b0;
        s_bready     = 1'b0;
        s_aw.addr    = aw_sel.addr;
        s_aw.len     = aw_sel.len[CNT_W-1:0];
        s_aw.size    = aw_sel.size[SIZE-1:0];
        s_aw.burst   = aw_sel.burst[SIZE-2:0];
        s_aw.id      = aw_sel.id[CNT_W-1:0];
        s_w          = m_w[gidx];
        s_w.last     = (beat_q == '0);
        unique case (state_q)
            ADDR: begin
                s_awvalid       = m_awvalid[gidx];
                m_awready[gidx] = s_awready;
            end
            DATA: begin
                s_wvalid       = m_wvalid[gidx];
                m_wready[gidx] = s_wready;
            end
            RESP: begin
                m_bvalid[gidx] = s_bvalid;
                m_bresp        = s_bresp;
                s_bready       = m_bready[gidx];
            end
            default: begin
            end
        endcase
    end

    // Ownership FSM: arbitrate, pass AW, count W beats, wait for B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|m_awvalid) begin
                        grant_q <= win;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_awvalid && s_awready) begin
                        beat_q  <= s_aw.len;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (s_wvalid && s_wready) begin
                        if (beat_q == '0) begin
                            state_q <= RESP;
                        end else begin
                            beat_q <= beat_q - 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (s_bvalid && s_bready) begin
                        ptr_q   <= ~gidx;
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_write_arbiter.sv
// Bench for axi3_write_arbiter: reactive masters/slave,
// a transaction-level model and literal scenario checks.
module tb_axi3_write_arbiter;
    import axi3_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0] m_bvalid, m_bready, m_bresp, grant;
    aw_t  [1:0] m_aw;
    w_t   [1:0] m_w;
    logic       s_awvalid, s_awready, s_wvalid, s_wready;
    logic       s_bvalid, s_bready;
    logic [1:0] s_bresp;
    aw_t        s_aw;
    w_t         s_w;

    axi3_write_arbiter #(.DATAWIDTH(32), .SIZE(3)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit mbusy, maw, mown, mprio;
    int mbeats, mlen;

    task automatic mreset();
        mbusy = 0; maw = 0; mown = 0; mprio = 0;
        mbeats = 0; mlen = 0;
    endtask

    task automatic mstep();
        if (!mbusy) begin
            if (m_awvalid != 2'b00) begin
                if (m_awvalid == 2'b11) mown = mprio;
                else mown = m_awvalid[1];
                mbusy = 1; maw = 0; mbeats = 0;
            end
        end else if (!maw) begin
            if (m_awvalid[mown] && s_awready) begin
                maw = 1;
                mlen = int'(m_aw[mown].len);
            end
        end else if (mbeats <= mlen) begin
            if (m_wvalid[mown] && s_wready) mbeats++;
        end else if (s_bvalid && m_bready[mown]) begin
            mprio = ~mown;
            mbusy = 0;
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mreset();
            else mstep();
        end
    end

    task automatic compare();
        logic [1:0] eg, eawr, ewr, ebv;
        bit pa, pd, pr, esaw, esw, esb;
        eg = '0; eawr = '0; ewr = '0; ebv = '0;
        pa = mbusy && !maw;
        pd = mbusy && maw && (mbeats <= mlen);
        pr = mbusy && maw && (mbeats > mlen);
        if (mbusy) eg[mown] = 1'b1;
        if (pa) eawr[mown] = s_awready;
        if (pd) ewr[mown] = s_wready;
        if (pr) ebv[mown] = s_bvalid;
        esaw = pa && m_awvalid[mown];
        esw  = pd && m_wvalid[mown];
        esb  = pr && m_bready[mown];
        chk("grant", 64'(grant), 64'(eg));
        chk("m_awready", 64'(m_awready), 64'(eawr));
        chk("m_wready", 64'(m_wready), 64'(ewr));
        chk("m_bvalid", 64'(m_bvalid), 64'(ebv));
        chk("s_awvalid", 64'(s_awvalid), 64'(esaw));
        chk("s_wvalid", 64'(s_wvalid), 64'(esw));
        chk("s_bready", 64'(s_bready), 64'(esb));
        if (esaw) chk("s_aw", 64'(s_aw), 64'(m_aw[mown]));
        if (esw) begin
            chk("s_w_data", 64'(s_w.data), 64'(m_w[mown].data));
            chk("s_w_strb", 64'(s_w.strb), 64'(m_w[mown].strb));
            chk("s_w_last", 64'(s_w.last), 64'(mbeats == mlen));
        end
        if (pr && s_bvalid)
            chk("m_bresp", 64'(m_bresp), 64'(s_bresp));
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    // ---------------- reactive masters and slave ----------------
    int          q_len[2][$];
    logic [31:0] q_addr[2][$];
    bit          aw_pend[2], b_wait[2], w_early[2];
    int          wleft[2], beat[2], txn[2], bhold[2], cur_len[2];
    logic [31:0] cur_addr[2];
    int          aw_stall, w_stall;
    bit          b_pend;
    logic [1:0]  next_resp;

    int          sw_beats, sw_last_cnt, sw_last_at;
    int          mw_cnt[2], rec_cnt[2];
    logic [1:0]  rec_resp[2];
    int          order[$];
    logic [31:0] aw_addr_rec;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i]   = aw_pend[i];
            m_aw[i].addr   = cur_addr[i];
            m_aw[i].len    = 4'(cur_len[i]);
            m_aw[i].size   = 3'd2;
            m_aw[i].burst  = 2'b01;
            m_aw[i].id     = 4'(i + 1);
            m_wvalid[i]    = (wleft[i] > 0) || (w_early[i] && aw_pend[i]);
            m_w[i].data    = {8'(i + 1), 8'(txn[i]), 16'(beat[i])};
            m_w[i].strb    = 4'(4'hF - i);
            m_w[i].last    = 1'b1;
            m_bready[i]    = (bhold[i] == 0);
        end
        s_awready = (aw_stall == 0);
        s_wready  = (w_stall == 0);
        s_bvalid  = b_pend;
        s_bresp   = next_resp;
    endtask

    task automatic drv_clear();
        for (int i = 0; i < 2; i++) begin
            q_len[i].delete(); q_addr[i].delete();
            aw_pend[i] = 0; b_wait[i] = 0; w_early[i] = 0;
            wleft[i] = 0; beat[i] = 0; bhold[i] = 0;
            cur_len[i] = 0; cur_addr[i] = '0;
        end
        aw_stall = 0; w_stall = 0; b_pend = 0; next_resp = OKAY;
        drive();
    endtask

    task automatic clear_rec();
        sw_beats = 0; sw_last_cnt = 0; sw_last_at = 0;
        order.delete(); aw_addr_rec = '0;
        for (int i = 0; i < 2; i++) begin
            mw_cnt[i] = 0; rec_cnt[i] = 0; rec_resp[i] = 2'b11;
        end
    endtask

    bit h_aw[2], h_w[2], h_b[2], bv[2];
    bit saw_hs, sw_hs, sw_last, sb_hs, awv_s, wv_s;
    int saw_who;
    logic [1:0]  bresp_s;
    logic [31:0] saw_addr;

    initial begin
        drv_clear();
        clear_rec();
        for (int i = 0; i < 2; i++) txn[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                h_aw[i] = m_awvalid[i] && m_awready[i];
                h_w[i]  = m_wvalid[i] && m_wready[i];
                h_b[i]  = m_bvalid[i] && m_bready[i];
                bv[i]   = m_bvalid[i];
            end
            saw_hs = s_awvalid && s_awready;
            saw_who = m_awready[1] ? 1 : 0;
            saw_addr = s_aw.addr;
            sw_hs = s_wvalid && s_wready;
            sw_last = s_w.last;
            sb_hs = s_bvalid && s_bready;
            awv_s = s_awvalid;
            wv_s = s_wvalid;
            bresp_s = m_bresp;
            @(posedge clk);
            #1;
            if (rst) begin
                drv_clear();
            end else begin
                if (saw_hs) begin
                    order.push_back(saw_who);
                    aw_addr_rec = saw_addr;
                end
                if (sw_hs) begin
                    sw_beats++;
                    if (sw_last) begin
                        sw_last_cnt++;
                        sw_last_at = sw_beats;
                        b_pend = 1;
                    end
                end
                if (sb_hs) b_pend = 0;
                if (awv_s && aw_stall > 0) aw_stall--;
                if (wv_s && w_stall > 0) w_stall--;
                for (int i = 0; i < 2; i++) begin
                    if (h_aw[i]) begin
                        aw_pend[i] = 0;
                        wleft[i] = cur_len[i] + 1;
                    end
                    if (h_w[i]) begin
                        wleft[i]--; beat[i]++; mw_cnt[i]++;
                    end
                    if (h_b[i]) begin
                        b_wait[i] = 0;
                        rec_resp[i] = bresp_s;
                        rec_cnt[i]++;
                    end
                    if (bv[i] && bhold[i] > 0) bhold[i]--;
                    if (!aw_pend[i] && wleft[i] == 0 && !b_wait[i]
                        && q_len[i].size() > 0) begin
                        cur_len[i] = q_len[i].pop_front();
                        cur_addr[i] = q_addr[i].pop_front();
                        aw_pend[i] = 1; b_wait[i] = 1;
                        beat[i] = 0; txn[i]++;
                    end
                end
                drive();
            end
        end
    end

    task automatic push(input int i, input int len, input logic [31:0] a);
        q_len[i].push_back(len);
        q_addr[i].push_back(a);
    endtask

    function automatic bit drv_idle();
        bit idle;
        idle = !b_pend && (grant == 2'b00);
        for (int i = 0; i < 2; i++) begin
            if (q_len[i].size() > 0 || aw_pend[i] || wleft[i] > 0
                || b_wait[i]) idle = 0;
        end
        return idle;
    endfunction

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drv_idle() && n < 400);
        chk(nm, 64'(n < 400), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Tie after reset: m0, m1, then m0 again on a second tie.
        @(negedge clk);
        clear_rec();
        push(0, 1, 32'h200); push(1, 2, 32'h300);
        wait_idle("idle_rr1");
        push(0, 0, 32'h210); push(1, 0, 32'h310);
        wait_idle("idle_rr2");
        chk("rr_count", 64'(order.size()), 64'(4));
        if (order.size() == 4) begin
            chk("rr_first", 64'(order[0]), 64'(0));
            chk("rr_second", 64'(order[1]), 64'(1));
            chk("rr_third", 64'(order[2]), 64'(0));
            chk("rr_fourth", 64'(order[3]), 64'(1));
        end

        // m0 alone, len 3 at 0x100.
        clear_rec();
        push(0, 3, 32'h100);
        wait_idle("idle_len3");
        chk("len3_beats", 64'(sw_beats), 64'(4));
        chk("len3_lastcnt", 64'(sw_last_cnt), 64'(1));
        chk("len3_lastat", 64'(sw_last_at), 64'(4));
        chk("len3_addr", 64'(aw_addr_rec), 64'h100);
        chk("len3_bcnt0", 64'(rec_cnt[0]), 64'(1));
        chk("len3_bresp", 64'(rec_resp[0]), 64'(OKAY));
        chk("len3_bcnt1", 64'(rec_cnt[1]), 64'(0));
        chk("len3_grant", 64'(grant), 64'(0));

        // len 0 with the slave stalling W for three cycles.
        clear_rec();
        w_stall = 3;
        push(0, 0, 32'h400);
        wait_idle("idle_len0");
        chk("len0_beats", 64'(sw_beats), 64'(1));
        chk("len0_lastcnt", 64'(sw_last_cnt), 64'(1));
        chk("len0_mwcnt", 64'(mw_cnt[0]), 64'(1));

        // m1 offers W early while AW is stalled two cycles.
        clear_rec();
        w_early[1] = 1;
        aw_stall = 2;
        push(1, 2, 32'h500);
        wait_idle("idle_early");
        w_early[1] = 0;
        chk("early_mwcnt", 64'(mw_cnt[1]), 64'(3));
        chk("early_beats", 64'(sw_beats), 64'(3));
        chk("early_lastat", 64'(sw_last_at), 64'(3));

        // SLVERR with the owner holding off B for two cycles.
        clear_rec();
        next_resp = SLVERR;
        bhold[0] = 2;
        push(0, 1, 32'h600);
        wait_idle("idle_slverr");
        next_resp = OKAY;
        chk("slverr_resp", 64'(rec_resp[0]), 64'(SLVERR));
        chk("slverr_cnt0", 64'(rec_cnt[0]), 64'(1));
        chk("slverr_cnt1", 64'(rec_cnt[1]), 64'(0));

        // Reset in the middle of a len 7 burst.
        clear_rec();
        push(0, 7, 32'h700);
        n = 0;
        while (beat[0] < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beat2_reached", 64'(n < 200), 64'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_m_awready", 64'(m_awready), 64'(0));
        chk("rst_m_wready", 64'(m_wready), 64'(0));
        chk("rst_m_bvalid", 64'(m_bvalid), 64'(0));
        chk("rst_s_awvalid", 64'(s_awvalid), 64'(0));
        chk("rst_s_wvalid", 64'(s_wvalid), 64'(0));
        chk("rst_s_bready", 64'(s_bready), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        clear_rec();
        push(1, 1, 32'h800); push(0, 1, 32'h900);
        wait_idle("idle_post_rst");
        chk("post_rst_count", 64'(order.size()), 64'(2));
        if (order.size() == 2) begin
            chk("post_rst_first", 64'(order[0]), 64'(0));
            chk("post_rst_second", 64'(order[1]), 64'(1));
        end
        chk("post_rst_beats", 64'(sw_beats), 64'(4));
        chk("post_rst_lastcnt", 64'(sw_last_cnt), 64'(2));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
